// File: rtl/rr_sweep_arbiter.sv
// Round-robin sweep arbiter for the event-camera readout path.
// Grants requesters in ascending index order once per sweep. Each grant is
// registered and held under a valid/ready handshake so the downstream
// address encoder can stall. At the end of a sweep the arbiter either
// parks until enable is re-armed (WRAP_EN=0) or restarts at once (WRAP_EN=1).
module rr_sweep_arbiter #(
    parameter int unsigned NUM_REQ = 8,
    parameter int unsigned ADDR_W  = $clog2(NUM_REQ),
    parameter bit          WRAP_EN = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               gnt_ready_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               gnt_valid_o,
    output logic [ADDR_W-1:0]  add_o,
    output logic               grp_release_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Lowest set index of a request vector (index 0 has highest priority).
    function automatic logic [ADDR_W-1:0] lowest_idx(input logic [NUM_REQ-1:0] vec);
        logic [ADDR_W-1:0] idx;
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = ADDR_W'(i);
            end
        end
        return idx;
    endfunction

    // One-hot decode of a binary index; kept in step with add_o by construction.
    function automatic logic [NUM_REQ-1:0] onehot(input logic [ADDR_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            oh[i] = (ADDR_W'(i) == idx);
        end
        return oh;
    endfunction

    // Mask with every bit strictly above idx set: what is still eligible
    // in the current sweep after idx has been served.
    function automatic logic [NUM_REQ-1:0] above_mask(input logic [ADDR_W-1:0] idx);
        logic [NUM_REQ-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            m[i] = (ADDR_W'(i) > idx);
        end
        return m;
    endfunction

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] mask_q,  mask_d;
    logic [NUM_REQ-1:0] gnt_q,   gnt_d;
    logic [ADDR_W-1:0]  add_q,   add_d;
    logic               valid_q, valid_d;
    logic               rel_q,   rel_d;

    logic [NUM_REQ-1:0] mreq_s;
    logic [NUM_REQ-1:0] nmask_s;
    logic [NUM_REQ-1:0] nreq_s;
    logic [ADDR_W-1:0]  sel_idx_s;
    logic [ADDR_W-1:0]  nsel_idx_s;

    // Candidate selections for a fresh grant and for a back-to-back grant.
    always_comb begin
        mreq_s     = req_i & mask_q;
        nmask_s    = above_mask(add_q);
        nreq_s     = req_i & nmask_s;
        sel_idx_s  = lowest_idx(mreq_s);
        nsel_idx_s = lowest_idx(nreq_s);
    end

    // Next-state and output-register logic of the sweep FSM.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        gnt_d   = gnt_q;
        add_d   = add_q;
        valid_d = valid_q;
        rel_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!enable) begin
                    mask_d = '1;
                end else if (mreq_s != '0) begin
                    gnt_d   = onehot(sel_idx_s);
                    add_d   = sel_idx_s;
                    valid_d = 1'b1;
                    state_d = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_GRANT: begin
                // The grant is held (req_i ignored) until it is accepted.
                if (valid_q && gnt_ready_i) begin
                    if (!enable) begin
                        gnt_d   = '0;
                        add_d   = '0;
                        valid_d = 1'b0;
                        mask_d  = '1;
                        state_d = ST_IDLE;
                    end else if (nreq_s != '0) begin
                        mask_d  = nmask_s;
                        gnt_d   = onehot(nsel_idx_s);
                        add_d   = nsel_idx_s;
                        valid_d = 1'b1;
                    end else begin
                        gnt_d   = '0;
                        add_d   = '0;
                        valid_d = 1'b0;
                        rel_d   = 1'b1;
                        if (WRAP_EN) begin
                            mask_d  = '1;
                            state_d = ST_IDLE;
                        end else begin
                            mask_d  = '0;
                            state_d = ST_DONE;
                        end
                    end
                end else begin
                    state_d = ST_GRANT;
                end
            end

            ST_DONE: begin
                // Parked: no grants until enable drops to re-arm the sweep.
                if (!enable) begin
                    mask_d  = '1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end

            default: begin
                gnt_d   = '0;
                add_d   = '0;
                valid_d = 1'b0;
                mask_d  = '1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and grant registers; reset clears outputs immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mask_q  <= '1;
            gnt_q   <= '0;
            add_q   <= '0;
            valid_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            gnt_q   <= gnt_d;
            add_q   <= add_d;
            valid_q <= valid_d;
            rel_q   <= rel_d;
        end
    end

    assign gnt_o         = gnt_q;
    assign add_o         = add_q;
    assign gnt_valid_o   = valid_q;
    assign grp_release_o = rel_q;

endmodule

// File: tb/tb_rr_sweep_arbiter.sv
// Self-checking bench for rr_sweep_arbiter: one instance per sweep-end mode,
// table-driven vectors checked through a per-instance scoreboard queue,
// plus hand-written reset-mid-grant and wrap sequences.
module tb_rr_sweep_arbiter;

    logic       clk;
    logic       reset;

    logic       en0, rdy0;
    logic [7:0] req0;
    logic [7:0] gnt0;
    logic       val0, rel0;
    logic [2:0] add0;

    logic       en1, rdy1;
    logic [7:0] req1;
    logic [7:0] gnt1;
    logic       val1, rel1;
    logic [2:0] add1;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic       valid;
        logic [2:0] add;
        logic       rel;
    } exp_t;

    typedef struct {
        logic       en;
        logic [7:0] req;
        logic       rdy;
        logic       ev;
        logic [2:0] ea;
        logic       er;
    } vec_t;

    exp_t sb0[$];
    exp_t sb1[$];
    vec_t vecs[30];

    rr_sweep_arbiter #(.NUM_REQ(8), .ADDR_W(3), .WRAP_EN(1'b0)) dut0 (
        .clk(clk), .reset(reset), .enable(en0), .req_i(req0),
        .gnt_ready_i(rdy0), .gnt_o(gnt0), .gnt_valid_o(val0),
        .add_o(add0), .grp_release_o(rel0)
    );

    rr_sweep_arbiter #(.NUM_REQ(8), .ADDR_W(3), .WRAP_EN(1'b1)) dut1 (
        .clk(clk), .reset(reset), .enable(en1), .req_i(req1),
        .gnt_ready_i(rdy1), .gnt_o(gnt1), .gnt_valid_o(val1),
        .add_o(add1), .grp_release_o(rel1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare all four outputs of the selected instance against one expectation.
    task automatic check_outs(input bit sel, input string tag, input exp_t e);
        logic [7:0] exp_gnt;
        exp_gnt = 8'h00;
        if (e.valid) exp_gnt[e.add] = 1'b1;
        if (sel) begin
            cmp({tag, ".valid"}, {7'd0, val1}, {7'd0, e.valid});
            cmp({tag, ".add"},   {5'd0, add1}, {5'd0, e.add});
            cmp({tag, ".gnt"},   gnt1,         exp_gnt);
            cmp({tag, ".rel"},   {7'd0, rel1}, {7'd0, e.rel});
        end else begin
            cmp({tag, ".valid"}, {7'd0, val0}, {7'd0, e.valid});
            cmp({tag, ".add"},   {5'd0, add0}, {5'd0, e.add});
            cmp({tag, ".gnt"},   gnt0,         exp_gnt);
            cmp({tag, ".rel"},   {7'd0, rel0}, {7'd0, e.rel});
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, then
    // pop and compare after the edge.
    task automatic apply(input bit sel, input logic en, input logic [7:0] req,
                         input logic rdy, input logic ev, input logic [2:0] ea,
                         input logic er, input string tag);
        exp_t e;
        e.valid = ev;
        e.add   = ea;
        e.rel   = er;
        if (sel) begin
            en1 = en; req1 = req; rdy1 = rdy;
            sb1.push_back(e);
        end else begin
            en0 = en; req0 = req; rdy0 = rdy;
            sb0.push_back(e);
        end
        @(posedge clk);
        #1;
        if (sel) begin
            if (sb1.size() == 0) begin
                n_assert++; n_fail++;
                $display("FAIL %s: scoreboard empty", tag);
            end else begin
                e = sb1.pop_front();
                check_outs(sel, tag, e);
            end
        end else begin
            if (sb0.size() == 0) begin
                n_assert++; n_fail++;
                $display("FAIL %s: scoreboard empty", tag);
            end else begin
                e = sb0.pop_front();
                check_outs(sel, tag, e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t zero_e;
        zero_e.valid = 1'b0;
        zero_e.add   = 3'd0;
        zero_e.rel   = 1'b0;

        // {enable, req, ready, exp_valid, exp_add, exp_release}
        vecs[0]  = '{1'b1, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0}; // no requests
        vecs[1]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 3'd0, 1'b0}; // full sweep
        vecs[2]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 3'd2, 1'b0};
        vecs[3]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 3'd5, 1'b0};
        vecs[4]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 3'd7, 1'b0};
        vecs[5]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 3'd0, 1'b1}; // sweep end
        vecs[6]  = '{1'b1, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b0}; // parked
        vecs[7]  = '{1'b1, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b0};
        vecs[8]  = '{1'b0, 8'hA5, 1'b1, 1'b0, 3'd0, 1'b0}; // re-arm
        vecs[9]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 3'd0, 1'b0};
        vecs[10] = '{1'b1, 8'hA5, 1'b1, 1'b1, 3'd2, 1'b0};
        vecs[11] = '{1'b1, 8'hFF, 1'b0, 1'b1, 3'd2, 1'b0}; // backpressure
        vecs[12] = '{1'b1, 8'h00, 1'b0, 1'b1, 3'd2, 1'b0};
        vecs[13] = '{1'b1, 8'h5A, 1'b0, 1'b1, 3'd2, 1'b0};
        vecs[14] = '{1'b1, 8'hA5, 1'b1, 1'b1, 3'd5, 1'b0};
        vecs[15] = '{1'b1, 8'hA5, 1'b1, 1'b1, 3'd7, 1'b0};
        vecs[16] = '{1'b1, 8'hA5, 1'b1, 1'b0, 3'd0, 1'b1};
        vecs[17] = '{1'b0, 8'hA5, 1'b1, 1'b0, 3'd0, 1'b0};
        vecs[18] = '{1'b1, 8'hA5, 1'b1, 1'b1, 3'd0, 1'b0}; // late low req
        vecs[19] = '{1'b1, 8'hA5, 1'b1, 1'b1, 3'd2, 1'b0};
        vecs[20] = '{1'b1, 8'hA7, 1'b1, 1'b1, 3'd5, 1'b0};
        vecs[21] = '{1'b1, 8'hA7, 1'b1, 1'b1, 3'd7, 1'b0};
        vecs[22] = '{1'b1, 8'hA7, 1'b1, 1'b0, 3'd0, 1'b1};
        vecs[23] = '{1'b0, 8'hA5, 1'b1, 1'b0, 3'd0, 1'b0};
        vecs[24] = '{1'b1, 8'hA5, 1'b1, 1'b1, 3'd0, 1'b0}; // enable drop
        vecs[25] = '{1'b1, 8'hA5, 1'b1, 1'b1, 3'd2, 1'b0};
        vecs[26] = '{1'b0, 8'hA5, 1'b0, 1'b1, 3'd2, 1'b0};
        vecs[27] = '{1'b0, 8'hA5, 1'b0, 1'b1, 3'd2, 1'b0};
        vecs[28] = '{1'b0, 8'hA5, 1'b1, 1'b0, 3'd0, 1'b0};
        vecs[29] = '{1'b1, 8'hA5, 1'b1, 1'b1, 3'd0, 1'b0};

        reset = 1'b1;
        en0 = 1'b0; req0 = 8'h00; rdy0 = 1'b0;
        en1 = 1'b0; req1 = 8'h00; rdy1 = 1'b0;
        #2;
        check_outs(1'b0, "reset0", zero_e);
        check_outs(1'b1, "reset1", zero_e);
        #10;
        reset = 1'b0;

        for (int i = 0; i < 30; i++) begin
            apply(1'b0, vecs[i].en, vecs[i].req, vecs[i].rdy,
                  vecs[i].ev, vecs[i].ea, vecs[i].er, $sformatf("vec%0d", i));
        end

        // Reset mid-grant: hold grant 2 with ready low, then reset off-edge.
        apply(1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 3'd2, 1'b0, "rst_pre_a");
        apply(1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 3'd2, 1'b0, "rst_pre_b");
        #2;
        reset = 1'b1;
        #1;
        check_outs(1'b0, "rst_async", zero_e);
        #3;
        reset = 1'b0;
        apply(1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 3'd0, 1'b0, "rst_first");
        apply(1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 3'd0, 1'b0, "rst_drop");

        // Wrap mode: 0,7, one idle cycle with release, then 0,7 again.
        apply(1'b1, 1'b1, 8'h81, 1'b1, 1'b1, 3'd0, 1'b0, "wrap0");
        apply(1'b1, 1'b1, 8'h81, 1'b1, 1'b1, 3'd7, 1'b0, "wrap1");
        apply(1'b1, 1'b1, 8'h81, 1'b1, 1'b0, 3'd0, 1'b1, "wrap2");
        apply(1'b1, 1'b1, 8'h81, 1'b1, 1'b1, 3'd0, 1'b0, "wrap3");
        apply(1'b1, 1'b1, 8'h81, 1'b1, 1'b1, 3'd7, 1'b0, "wrap4");
        apply(1'b1, 1'b1, 8'h81, 1'b1, 1'b0, 3'd0, 1'b1, "wrap5");
        apply(1'b1, 1'b1, 8'h81, 1'b1, 1'b1, 3'd0, 1'b0, "wrap6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
